cu_adain_mc: RTL and testbench

Multi-channel, handshake-driven control unit for the AdaIN datapath. It sequences per-channel statistics passes (accumulate, variance, inverse sigma, B1, B0) and a normalisation pass across up to C_MAX channels of an N×N feature map. Input samples arrive through a valid/ready handshake, so the upstream feature buffer can stall freely. It drives the shared multiplier/offset/accumulator datapath select lines and the per-channel parameter-memory address.

---
 rtl/cu_adain_mc.sv | 278 +++++++++++++++++++++++++++
 tb/tb_cu_adain_mc.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cu_adain_mc.sv
// AdaIN control unit: sequences per-channel statistics passes and the normalisation pass.
// Optional ADAIN_EPS_EN inserts an epsilon-add phase (state code 7) between VAR and ISIG.
module cu_adain_mc #(
    parameter int N_MAX = 128,
    parameter int C_MAX = 256,
    parameter int LAT   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       mode,
    input  logic [$clog2(N_MAX+1)-1:0] N,
    input  logic [$clog2(C_MAX+1)-1:0] C,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [2:0]                 state,
    output logic [$clog2(C_MAX)-1:0]   ch_idx,
    output logic [1:0]                 multiplicand_sel,
    output logic [2:0]                 multiplier_sel,
    output logic [1:0]                 offset_sel,
    output logic [1:0]                 add2_sel,
    output logic                       rst_mult,
    output logic                       rst_offset,
    output logic                       rst_acc,
    output logic                       variance_en,
    output logic                       inv_sigma_en,
    output logic                       B1_en,
    output logic                       B0_en,
    output logic                       out_en,
    output logic [1:0]                 done,
    output logic                       busy
);

    localparam int NW = $clog2(N_MAX + 1);
    localparam int CW = $clog2(C_MAX + 1);
    localparam int RW = $clog2(N_MAX);
    localparam int IW = $clog2(C_MAX);
    localparam int PW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ACC  = 3'd1,
        S_VAR  = 3'd2,
        S_ISIG = 3'd3,
        S_B1   = 3'd4,
        S_B0   = 3'd5,
        S_NORM = 3'd6,
        S_EPS  = 3'd7
    } state_t;

    state_t          st, nxt_st;
    logic [RW-1:0]   n_last, nxt_n_last;
    logic [IW-1:0]   c_last, nxt_c_last;
    logic [RW-1:0]   col, nxt_col;
    logic [RW-1:0]   row, nxt_row;
    logic [IW-1:0]   ch, nxt_ch;
    logic            flush, nxt_flush;
    logic [PW-1:0]   cnt, nxt_cnt;
    logic            acc_first, nxt_acc_first;
    logic [1:0]      done_q, nxt_done;
    logic [LAT-1:0]  oe_sr;

    logic            accept;
    logic            last_sample;
    logic            phase_end;
    logic [NW-1:0]   n_m1;
    logic [CW-1:0]   c_m1;

    assign in_ready    = ((st == S_ACC) || (st == S_NORM)) && !flush;
    assign accept      = in_valid & in_ready;
    assign last_sample = (col == n_last) && (row == n_last);
    assign phase_end   = (cnt == PW'(LAT - 1));
    assign n_m1        = N - NW'(1);
    assign c_m1        = C - CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= S_IDLE;
            n_last    <= '0;
            c_last    <= '0;
            col       <= '0;
            row       <= '0;
            ch        <= '0;
            flush     <= 1'b0;
            cnt       <= '0;
            acc_first <= 1'b0;
            done_q    <= '0;
            oe_sr     <= '0;
        end else begin
            st        <= nxt_st;
            n_last    <= nxt_n_last;
            c_last    <= nxt_c_last;
            col       <= nxt_col;
            row       <= nxt_row;
            ch        <= nxt_ch;
            flush     <= nxt_flush;
            cnt       <= nxt_cnt;
            acc_first <= nxt_acc_first;
            done_q    <= nxt_done;
            // out_en replays NORM accepts LAT cycles later, so stalls propagate exactly
            oe_sr[0]  <= accept && (st == S_NORM);
            for (int unsigned i = 1; i < LAT; i++) begin
                oe_sr[i] <= oe_sr[i-1];
            end
        end
    end

    always_comb begin
        nxt_st        = st;
        nxt_n_last    = n_last;
        nxt_c_last    = c_last;
        nxt_col       = col;
        nxt_row       = row;
        nxt_ch        = ch;
        nxt_flush     = flush;
        nxt_cnt       = cnt;
        nxt_acc_first = 1'b0;
        nxt_done      = 2'b00;

        multiplicand_sel = 2'd0;
        multiplier_sel   = 3'd0;
        offset_sel       = 2'd0;
        add2_sel         = 2'd0;
        rst_mult         = 1'b0;
        rst_offset       = 1'b1;
        rst_acc          = 1'b0;
        variance_en      = 1'b0;
        inv_sigma_en     = 1'b0;
        B1_en            = 1'b0;
        B0_en            = 1'b0;

        case (st)
            S_IDLE: begin
                rst_mult = 1'b1;
                if (start) begin
                    if ((N != '0) && (C != '0)) begin
                        nxt_n_last    = n_m1[RW-1:0];
                        nxt_c_last    = c_m1[IW-1:0];
                        nxt_ch        = '0;
                        nxt_col       = '0;
                        nxt_row       = '0;
                        nxt_flush     = 1'b0;
                        nxt_cnt       = '0;
                        nxt_st        = mode ? S_NORM : S_ACC;
                        nxt_acc_first = !mode;
                    end else begin
                        nxt_done = 2'b11;
                    end
                end
            end

            S_ACC, S_NORM: begin
                if (st == S_ACC) begin
                    add2_sel = 2'd1;
                    rst_acc  = acc_first;
                end else begin
                    multiplier_sel = 3'd4;
                    offset_sel     = 2'd2;
                    rst_offset     = 1'b0;
                end
                if (flush) begin
                    nxt_cnt = cnt + PW'(1);
                    if (phase_end) begin
                        nxt_cnt   = '0;
                        nxt_flush = 1'b0;
                        if (st == S_ACC) begin
                            nxt_st = S_VAR;
                        end else if (ch == c_last) begin
                            nxt_st   = S_IDLE;
                            nxt_done = 2'b10;
                        end else begin
                            nxt_ch  = ch + IW'(1);
                            nxt_col = '0;
                            nxt_row = '0;
                        end
                    end
                end else if (accept) begin
                    if (last_sample) begin
                        nxt_flush = 1'b1;
                        nxt_cnt   = '0;
                    end else if (col == n_last) begin
                        nxt_col = '0;
                        nxt_row = row + RW'(1);
                    end else begin
                        nxt_col = col + RW'(1);
                    end
                end
            end

            S_VAR: begin
                multiplicand_sel = 2'd1;
                multiplier_sel   = 3'd1;
                add2_sel         = 2'd1;
                variance_en      = 1'b1;
                nxt_cnt          = cnt + PW'(1);
                if (phase_end) begin
                    nxt_cnt = '0;
`ifdef ADAIN_EPS_EN
                    nxt_st  = S_EPS;
`else
                    nxt_st  = S_ISIG;
`endif
                end
            end

`ifdef ADAIN_EPS_EN
            S_EPS: begin
                multiplicand_sel = 2'd1;
                offset_sel       = 2'd3;
                add2_sel         = 2'd1;
                variance_en      = 1'b1;
                nxt_cnt          = cnt + PW'(1);
                if (phase_end) begin
                    nxt_cnt = '0;
                    nxt_st  = S_ISIG;
                end
            end
`endif

            S_ISIG: begin
                multiplicand_sel = 2'd2;
                multiplier_sel   = 3'd2;
                rst_offset       = 1'b0;
                inv_sigma_en     = 1'b1;
                nxt_cnt          = cnt + PW'(1);
                if (phase_end) begin
                    nxt_cnt = '0;
                    nxt_st  = S_B1;
                end
            end

            S_B1: begin
                multiplicand_sel = 2'd3;
                multiplier_sel   = 3'd3;
                B1_en            = 1'b1;
                nxt_cnt          = cnt + PW'(1);
                if (phase_end) begin
                    nxt_cnt = '0;
                    nxt_st  = S_B0;
                end
            end

            S_B0: begin
                multiplicand_sel = 2'd1;
                multiplier_sel   = 3'd4;
                offset_sel       = 2'd1;
                rst_offset       = 1'b0;
                B0_en            = 1'b1;
                nxt_cnt          = cnt + PW'(1);
                if (phase_end) begin
                    nxt_cnt = '0;
                    if (ch == c_last) begin
                        nxt_st   = S_IDLE;
                        nxt_done = 2'b01;
                    end else begin
                        nxt_ch        = ch + IW'(1);
                        nxt_col       = '0;
                        nxt_row       = '0;
                        nxt_st        = S_ACC;
                        nxt_acc_first = 1'b1;
                    end
                end
            end

            default: begin
                rst_mult = 1'b1;
                nxt_st   = S_IDLE;
            end
        endcase
    end

    assign state  = st;
    assign ch_idx = ch;
    assign out_en = oe_sr[LAT-1];
    assign done   = done_q;
    assign busy   = (st != S_IDLE);

endmodule

// File: tb/tb_cu_adain_mc.sv
// Directed bench for cu_adain_mc (LAT=4): stats, stalled stats, norm, reject, reset, back-to-back.
module tb_cu_adain_mc;

    localparam int LAT = 4;
`ifdef ADAIN_EPS_EN
    localparam int E = 4;
`else
    localparam int E = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] N = 8'd0;
    logic [8:0] C = 9'd0;
    logic       in_valid = 1'b0;

    logic       in_ready;
    logic [2:0] state;
    logic [7:0] ch_idx;
    logic [1:0] multiplicand_sel;
    logic [2:0] multiplier_sel;
    logic [1:0] offset_sel;
    logic [1:0] add2_sel;
    logic       rst_mult, rst_offset, rst_acc;
    logic       variance_en, inv_sigma_en, B1_en, B0_en, out_en;
    logic [1:0] done;
    logic       busy;
    logic [15:0] ctl_obs;

    int vectors = 0;
    int errors  = 0;

    cu_adain_mc #(.N_MAX(128), .C_MAX(256), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .N(N), .C(C),
        .in_valid(in_valid), .in_ready(in_ready), .state(state), .ch_idx(ch_idx),
        .multiplicand_sel(multiplicand_sel), .multiplier_sel(multiplier_sel),
        .offset_sel(offset_sel), .add2_sel(add2_sel),
        .rst_mult(rst_mult), .rst_offset(rst_offset), .rst_acc(rst_acc),
        .variance_en(variance_en), .inv_sigma_en(inv_sigma_en),
        .B1_en(B1_en), .B0_en(B0_en), .out_en(out_en), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    assign ctl_obs = {multiplicand_sel, multiplier_sel, offset_sel, add2_sel,
                      rst_mult, rst_offset, variance_en, inv_sigma_en, B1_en, B0_en, busy};

    // {mcand, mplier, offset, add2, rst_mult, rst_offset, var_en, isig_en, b1_en, b0_en, busy}
    function automatic logic [15:0] ctl_of(input logic [2:0] s);
        case (s)
            3'd1:    ctl_of = {2'd0, 3'd0, 2'd0, 2'd1, 7'b0100001};
            3'd2:    ctl_of = {2'd1, 3'd1, 2'd0, 2'd1, 7'b0110001};
            3'd3:    ctl_of = {2'd2, 3'd2, 2'd0, 2'd0, 7'b0001001};
            3'd4:    ctl_of = {2'd3, 3'd3, 2'd0, 2'd0, 7'b0100101};
            3'd5:    ctl_of = {2'd1, 3'd4, 2'd1, 2'd0, 7'b0000011};
            3'd6:    ctl_of = {2'd0, 3'd4, 2'd2, 2'd0, 7'b0000001};
            3'd7:    ctl_of = {2'd1, 3'd0, 2'd3, 2'd1, 7'b0110001};
            default: ctl_of = {2'd0, 3'd0, 2'd0, 2'd0, 7'b1100000};
        endcase
    endfunction

    // Expected state of a single-channel stats pass whose last ACC cycle is acc_end.
    function automatic logic [2:0] stats_state(input int t, input int acc_end);
        if (t < 1)                         stats_state = 3'd0;
        else if (t <= acc_end)             stats_state = 3'd1;
        else if (t <= acc_end + 4)         stats_state = 3'd2;
        else if (t <= acc_end + 4 + E)     stats_state = 3'd7;
        else if (t <= acc_end + 8 + E)     stats_state = 3'd3;
        else if (t <= acc_end + 12 + E)    stats_state = 3'd4;
        else if (t <= acc_end + 16 + E)    stats_state = 3'd5;
        else                               stats_state = 3'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        start = 1'b1; mode = 1'b0; N = 8'd2; C = 9'd1; in_valid = 1'b1;
        tick();
        tick();
        vectors++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d expected 0", state); end
        vectors++; if (ctl_obs !== ctl_of(3'd0)) begin errors++; $display("FAIL reset_ctl got %h expected %h", ctl_obs, ctl_of(3'd0)); end
        vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b expected 0", in_ready); end
        vectors++; if (ch_idx !== 8'd0) begin errors++; $display("FAIL reset_ch_idx got %0d expected 0", ch_idx); end
        vectors++; if (done !== 2'b00) begin errors++; $display("FAIL reset_done got %b expected 00", done); end
        vectors++; if ({rst_acc, out_en} !== 2'b00) begin errors++; $display("FAIL reset_acc_oe got %b expected 00", {rst_acc, out_en}); end
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        tick();
        vectors++; if (state !== 3'd0) begin errors++; $display("FAIL post_reset_state got %0d expected 0", state); end
    endtask

    task automatic test_stats(input int sh);
        logic [2:0] es;
        logic [1:0] ed;
        tick();
        start = 1'b1; mode = 1'b0; N = 8'd2; C = 9'd1; in_valid = 1'b1;
        for (int t = 1; t <= 26 + sh + E; t++) begin
            tick();
            start = 1'b0;
            in_valid = (sh != 0 && (t == 2 || t == 3)) ? 1'b0 : 1'b1;
            es = stats_state(t, 8 + sh);
            ed = (t == 25 + sh + E) ? 2'b01 : 2'b00;
            vectors++; if (state !== es) begin errors++; $display("FAIL stats_state sh=%0d t=%0d got %0d expected %0d", sh, t, state, es); end
            vectors++; if (ctl_obs !== ctl_of(es)) begin errors++; $display("FAIL stats_ctl sh=%0d t=%0d got %h expected %h", sh, t, ctl_obs, ctl_of(es)); end
            vectors++; if (in_ready !== (t <= 4 + sh)) begin errors++; $display("FAIL stats_in_ready sh=%0d t=%0d got %b", sh, t, in_ready); end
            vectors++; if (done !== ed) begin errors++; $display("FAIL stats_done sh=%0d t=%0d got %b expected %b", sh, t, done, ed); end
            vectors++; if (rst_acc !== (t == 1)) begin errors++; $display("FAIL stats_rst_acc sh=%0d t=%0d got %b", sh, t, rst_acc); end
            vectors++; if (ch_idx !== 8'd0) begin errors++; $display("FAIL stats_ch_idx sh=%0d t=%0d got %0d expected 0", sh, t, ch_idx); end
            vectors++; if (out_en !== 1'b0) begin errors++; $display("FAIL stats_out_en sh=%0d t=%0d got %b expected 0", sh, t, out_en); end
        end
    endtask

    task automatic test_norm();
        logic [2:0] es;
        logic [1:0] ed;
        logic       er, eo;
        int p, k;
        tick();
        start = 1'b1; mode = 1'b1; N = 8'd2; C = 9'd3; in_valid = 1'b1;
        for (int t = 1; t <= 26; t++) begin
            tick();
            start = (t == 5);
            if (t == 5) begin N = 8'd0; C = 9'd0; mode = 1'b0; end
            p  = (t - 1) % 8;
            k  = (t - 1) / 8;
            es = (t <= 24) ? 3'd6 : 3'd0;
            er = (t <= 24) && (p < 4);
            eo = (t <= 24) && (p >= 4);
            ed = (t == 25) ? 2'b10 : 2'b00;
            vectors++; if (state !== es) begin errors++; $display("FAIL norm_state t=%0d got %0d expected %0d", t, state, es); end
            vectors++; if (ctl_obs !== ctl_of(es)) begin errors++; $display("FAIL norm_ctl t=%0d got %h expected %h", t, ctl_obs, ctl_of(es)); end
            vectors++; if (in_ready !== er) begin errors++; $display("FAIL norm_in_ready t=%0d got %b expected %b", t, in_ready, er); end
            vectors++; if (out_en !== eo) begin errors++; $display("FAIL norm_out_en t=%0d got %b expected %b", t, out_en, eo); end
            vectors++; if (done !== ed) begin errors++; $display("FAIL norm_done t=%0d got %b expected %b", t, done, ed); end
            if (t <= 24) begin
                vectors++; if (ch_idx !== 8'(k)) begin errors++; $display("FAIL norm_ch_idx t=%0d got %0d expected %0d", t, ch_idx, k); end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reject();
        logic [7:0] nv [2] = '{8'd2, 8'd0};
        logic [8:0] cv [2] = '{9'd0, 9'd1};
        for (int i = 0; i < 2; i++) begin
            tick();
            start = 1'b1; mode = 1'b0; N = nv[i]; C = cv[i]; in_valid = 1'b1;
            tick();
            start = 1'b0;
            vectors++; if (done !== 2'b11) begin errors++; $display("FAIL reject_done case=%0d got %b expected 11", i, done); end
            vectors++; if (state !== 3'd0) begin errors++; $display("FAIL reject_state case=%0d got %0d expected 0", i, state); end
            vectors++; if ({in_ready, busy} !== 2'b00) begin errors++; $display("FAIL reject_ready_busy case=%0d got %b expected 00", i, {in_ready, busy}); end
            tick();
            vectors++; if (done !== 2'b00) begin errors++; $display("FAIL reject_pulse case=%0d got %b expected 00", i, done); end
            vectors++; if (state !== 3'd0) begin errors++; $display("FAIL reject_state2 case=%0d got %0d expected 0", i, state); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [2:0] es;
        logic [7:0] ec;
        tick();
        start = 1'b1; mode = 1'b0; N = 8'd2; C = 9'd2; in_valid = 1'b1;
        for (int t = 1; t <= 38 + E; t++) begin
            tick();
            start = 1'b0;
            es = (t <= 24 + E) ? stats_state(t, 8) : stats_state(t - 24 - E, 8);
            ec = (t <= 24 + E) ? 8'd0 : 8'd1;
            vectors++; if (state !== es) begin errors++; $display("FAIL mid_state t=%0d got %0d expected %0d", t, state, es); end
            vectors++; if (ch_idx !== ec) begin errors++; $display("FAIL mid_ch_idx t=%0d got %0d expected %0d", t, ch_idx, ec); end
            vectors++; if (rst_acc !== (t == 1 || t == 25 + E)) begin errors++; $display("FAIL mid_rst_acc t=%0d got %b", t, rst_acc); end
            vectors++; if (done !== 2'b00) begin errors++; $display("FAIL mid_done t=%0d got %b expected 00", t, done); end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++; if (state !== 3'd0) begin errors++; $display("FAIL mid_rst_state got %0d expected 0", state); end
        vectors++; if (ctl_obs !== ctl_of(3'd0)) begin errors++; $display("FAIL mid_rst_ctl got %h expected %h", ctl_obs, ctl_of(3'd0)); end
        vectors++; if (ch_idx !== 8'd0) begin errors++; $display("FAIL mid_rst_ch_idx got %0d expected 0", ch_idx); end
        vectors++; if ({in_ready, rst_acc, out_en} !== 3'b000) begin errors++; $display("FAIL mid_rst_misc got %b expected 000", {in_ready, rst_acc, out_en}); end
        for (int t = 0; t < 6; t++) begin
            vectors++; if (done !== 2'b00) begin errors++; $display("FAIL mid_no_done t=%0d got %b expected 00", t, done); end
            vectors++; if (state !== 3'd0) begin errors++; $display("FAIL mid_idle t=%0d got %0d expected 0", t, state); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] es;
        logic [1:0] ed;
        start = 1'b1; mode = 1'b0; N = 8'd1; C = 9'd1; in_valid = 1'b1;
        for (int t = 1; t <= 28 + E; t++) begin
            tick();
            start = (t == 22 + E);
            mode  = (t == 22 + E);
            es = (t <= 22 + E) ? stats_state(t, 5) : ((t <= 27 + E) ? 3'd6 : 3'd0);
            ed = (t == 22 + E) ? 2'b01 : ((t == 28 + E) ? 2'b10 : 2'b00);
            vectors++; if (state !== es) begin errors++; $display("FAIL b2b_state t=%0d got %0d expected %0d", t, state, es); end
            vectors++; if (ctl_obs !== ctl_of(es)) begin errors++; $display("FAIL b2b_ctl t=%0d got %h expected %h", t, ctl_obs, ctl_of(es)); end
            vectors++; if (done !== ed) begin errors++; $display("FAIL b2b_done t=%0d got %b expected %b", t, done, ed); end
            vectors++; if (in_ready !== (t == 1 || t == 23 + E)) begin errors++; $display("FAIL b2b_in_ready t=%0d got %b", t, in_ready); end
            vectors++; if (out_en !== (t == 27 + E)) begin errors++; $display("FAIL b2b_out_en t=%0d got %b", t, out_en); end
            vectors++; if (ch_idx !== 8'd0) begin errors++; $display("FAIL b2b_ch_idx t=%0d got %0d expected 0", t, ch_idx); end
            vectors++; if (rst_acc !== (t == 1)) begin errors++; $display("FAIL b2b_rst_acc t=%0d got %b", t, rst_acc); end
        end
        start = 1'b0; mode = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stats(0);
        test_stats(2);
        test_norm();
        test_reject();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
